wishbone_crossbar: RTL and testbench
====================================

// Module: wishbone_crossbar
// PURPOSE
//  - MASTER_COUNT x SLAVE_COUNT Wishbone (classic, tagged) crossbar for the SoC package interconnect.
//  - Decodes each master's address to one slave window.
//  - Each slave has its own round-robin arbiter, so masters targeting different slaves proceed concurrently.
//  - Handshake and data route back to the owning master; unmapped accesses terminate with err.
// PARAMETERS
//  DATA_WIDTH    32  data bus width; SEL_WIDTH = DATA_WIDTH/8
//  ADDR_WIDTH    32  byte address width
//  MASTER_COUNT  2   number of master ports (>=1)
//  SLAVE_COUNT   2   number of slave ports (>=1)
//  SLAVE_ADDR    0   [ADDR_WIDTH*SLAVE_COUNT-1:0]; base of slave i at [ADDR_WIDTH*i +: ADDR_WIDTH]
//  SLAVE_MASK    0   same packing; set bits = offset bits inside the window (1KB window -> 32'h3FF)
//  TAG_WIDTH is fixed at 3.
// PORTS
//  sys_clk  in   1                  system clock; all state on posedge
//  sys_rst  in   1                  synchronous, active-high reset
//  m_cyc    in   MASTER_COUNT       per-master cycle
//  m_stb    in   MASTER_COUNT       per-master strobe
//  m_we     in   MASTER_COUNT       per-master write enable
//  m_tag    in   3*MASTER_COUNT     per-master tag, master j at [3*j +: 3]
//  m_sel    in   SEL_WIDTH*MC       byte selects
//  m_adr    in   ADDR_WIDTH*MC      addresses
//  m_mosi   in   DATA_WIDTH*MC      write data
//  m_miso   out  DATA_WIDTH*MC      read data to masters
//  m_ack    out  MASTER_COUNT       ack to masters
//  m_err    out  MASTER_COUNT       err to masters
//  s_cyc, s_stb, s_we, s_tag, s_sel, s_adr, s_mosi  out  as m_* but per slave (SLAVE_COUNT lanes)
//  s_miso   in   DATA_WIDTH*SC      slave read data
//  s_ack    in   SLAVE_COUNT        slave ack
//  s_err    in   SLAVE_COUNT        slave err
// BEHAVIOUR
//  - Address decode: master j hits slave i iff (adr_j & ~MASK_i) == (ADDR_i & ~MASK_i).
//  - Multiple hits: lowest slave index wins.
//  - Request: req[i][j] = m_cyc[j] & hit(j,i).
//  - Grant: per slave, registered owner (valid + index).
//    - Idle with requests: at the next edge, grant the first requesting master after the previous owner (round-robin, wrap at MASTER_COUNT-1 -> 0).
//    - The previous owner resets to MASTER_COUNT-1, so master 0 wins first.
//    - Held while the owner's m_cyc=1; released at the edge where the owner's m_cyc=0.
//    - A new grant is issued no earlier than the following edge (1 idle cycle between owners).
//  - Forward path, combinational from the grant: s_* of slave i = owner's signals.
//    - All s_* outputs are 0 while the slave is idle.
//  - Return path, combinational:
//    - Owner's m_ack = s_ack[i] & m_stb, m_err = s_err[i] & m_stb, m_miso = s_miso[i].
//    - Non-owners, and masters with nothing granted, see ack=err=0 and miso=0.
//  - Latency: master raises cyc/stb in cycle N; slave sees stb in N+1 (if free); a combinational slave ack reaches the master in N+1.
//  - Masters hold adr/we/sel/tag stable for the whole cycle; a master blocked on a busy slave waits with no ack.
//  - Unmapped: m_cyc & m_stb with no hit -> registered m_err pulse for exactly 1 cycle, next cycle.
//    - It repeats every other cycle if the master keeps stb high.
//    - No slave sees the access.
//  - A master never owns more than one slave, because grants follow its single address.
//  - Reset: all grants cleared, round-robin pointers set so master 0 wins first, err regs 0.
//    - All outputs are therefore 0 in the cycle after reset.
//    - Reset mid-transfer drops the grant immediately; no ack is issued after reset.
// TESTING
//  - Reset: sys_rst=1 with both masters requesting -> all s_*/m_ack/m_err/m_miso = 0 while reset is held.
//  - Single master, adr 0x000, SLAVE_ADDR={0x000,0x400}, masks 0x3FF:
//    - Slave 1 gets cyc/stb 1 cycle later.
//    - Slave ack=stb -> m_ack[0]=1 that cycle.
//    - Slave 0 stays idle.
//  - Two masters, both adr 0x000, continuous requests -> grants alternate M0,M1,M0...
//    - Each ack is exclusive; never both m_ack high.
//  - M0 -> 0x000, M1 -> 0x400 simultaneously -> both granted the same cycle; both acked concurrently.
//  - Master adr 0x800 (unmapped) -> m_err=1 for one cycle; s_cyc stays 0; m_ack stays 0.
//  - Read data: slave 0 drives s_miso=0xDEADBEEF, M1 owns it -> m_miso[63:32]=0xDEADBEEF and m_miso[31:0]=0.

Source files
------------

// File: rtl/wishbone_crossbar.sv
// MASTER_COUNT x SLAVE_COUNT Wishbone crossbar: per-master address decode, per-slave round-robin
// owner register, combinational forward/return routing and a registered err for unmapped accesses.
module wishbone_crossbar #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MASTER_COUNT = 2,
  parameter int SLAVE_COUNT  = 2,
  parameter logic [ADDR_WIDTH*SLAVE_COUNT-1:0] SLAVE_ADDR = '0,
  parameter logic [ADDR_WIDTH*SLAVE_COUNT-1:0] SLAVE_MASK = '0
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst,
  input  logic [MASTER_COUNT-1:0]               m_cyc,
  input  logic [MASTER_COUNT-1:0]               m_stb,
  input  logic [MASTER_COUNT-1:0]               m_we,
  input  logic [3*MASTER_COUNT-1:0]             m_tag,
  input  logic [(DATA_WIDTH/8)*MASTER_COUNT-1:0] m_sel,
  input  logic [ADDR_WIDTH*MASTER_COUNT-1:0]    m_adr,
  input  logic [DATA_WIDTH*MASTER_COUNT-1:0]    m_mosi,
  output logic [DATA_WIDTH*MASTER_COUNT-1:0]    m_miso,
  output logic [MASTER_COUNT-1:0]               m_ack,
  output logic [MASTER_COUNT-1:0]               m_err,
  output logic [SLAVE_COUNT-1:0]                s_cyc,
  output logic [SLAVE_COUNT-1:0]                s_stb,
  output logic [SLAVE_COUNT-1:0]                s_we,
  output logic [3*SLAVE_COUNT-1:0]              s_tag,
  output logic [(DATA_WIDTH/8)*SLAVE_COUNT-1:0] s_sel,
  output logic [ADDR_WIDTH*SLAVE_COUNT-1:0]     s_adr,
  output logic [DATA_WIDTH*SLAVE_COUNT-1:0]     s_mosi,
  input  logic [DATA_WIDTH*SLAVE_COUNT-1:0]     s_miso,
  input  logic [SLAVE_COUNT-1:0]                s_ack,
  input  logic [SLAVE_COUNT-1:0]                s_err
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int TAG_WIDTH = 3;
  localparam int MIDX_W    = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
  localparam int SIDX_W    = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;

  logic [MASTER_COUNT-1:0] any_hit;
  logic [SIDX_W-1:0]       hit_idx [MASTER_COUNT];
  logic [MASTER_COUNT-1:0] req     [SLAVE_COUNT];
  logic [MIDX_W-1:0]       rr_next [SLAVE_COUNT];
  logic [SLAVE_COUNT-1:0]  own_valid;
  logic [MIDX_W-1:0]       own_idx [SLAVE_COUNT];
  logic [SLAVE_COUNT-1:0]  active;
  logic [MASTER_COUNT-1:0] err_q;

  // Scan slaves high-to-low so the lowest matching window wins.
  always_comb begin
    for (int j = 0; j < MASTER_COUNT; j++) begin
      any_hit[j] = 1'b0;
      hit_idx[j] = '0;
      for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
        if ((m_adr[j*ADDR_WIDTH +: ADDR_WIDTH] & ~SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
            (SLAVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] & ~SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          any_hit[j] = 1'b1;
          hit_idx[j] = SIDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      for (int j = 0; j < MASTER_COUNT; j++) begin
        req[i][j] = m_cyc[j] & any_hit[j] & (hit_idx[j] == SIDX_W'(i));
      end
    end
  end

  // own_idx doubles as the round-robin pointer: it keeps the last owner after release.
  always_comb begin
    int cand;
    cand = 0;
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      rr_next[i] = own_idx[i];
      for (int k = MASTER_COUNT; k >= 1; k--) begin
        cand = (int'(own_idx[i]) + k) % MASTER_COUNT;
        if (req[i][cand]) rr_next[i] = MIDX_W'(cand);
      end
    end
  end

  assign active = own_valid & {SLAVE_COUNT{~sys_rst}};

  always_comb begin
    s_cyc  = '0;
    s_stb  = '0;
    s_we   = '0;
    s_tag  = '0;
    s_sel  = '0;
    s_adr  = '0;
    s_mosi = '0;
    m_ack  = '0;
    m_err  = err_q & {MASTER_COUNT{~sys_rst}};
    m_miso = '0;
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      for (int j = 0; j < MASTER_COUNT; j++) begin
        if (active[i] && own_idx[i] == MIDX_W'(j)) begin
          s_cyc[i] = m_cyc[j];
          s_stb[i] = m_stb[j];
          s_we[i]  = m_we[j];
          s_tag[i*TAG_WIDTH +: TAG_WIDTH]   = m_tag[j*TAG_WIDTH +: TAG_WIDTH];
          s_sel[i*SEL_WIDTH +: SEL_WIDTH]   = m_sel[j*SEL_WIDTH +: SEL_WIDTH];
          s_adr[i*ADDR_WIDTH +: ADDR_WIDTH] = m_adr[j*ADDR_WIDTH +: ADDR_WIDTH];
          s_mosi[i*DATA_WIDTH +: DATA_WIDTH] = m_mosi[j*DATA_WIDTH +: DATA_WIDTH];
          m_ack[j] = s_ack[i] & m_stb[j];
          m_err[j] = m_err[j] | (s_err[i] & m_stb[j]);
          m_miso[j*DATA_WIDTH +: DATA_WIDTH] = s_miso[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Release and grant are exclusive per edge, which leaves one idle cycle between owners.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      own_valid <= '0;
      err_q     <= '0;
      for (int i = 0; i < SLAVE_COUNT; i++) own_idx[i] <= MIDX_W'(MASTER_COUNT - 1);
    end else begin
      for (int i = 0; i < SLAVE_COUNT; i++) begin
        if (own_valid[i]) begin
          if (!s_cyc[i]) own_valid[i] <= 1'b0;
        end else if (|req[i]) begin
          own_valid[i] <= 1'b1;
          own_idx[i]   <= rr_next[i];
        end
      end
      err_q <= m_cyc & m_stb & ~any_hit & ~err_q;
    end
  end

endmodule

// File: tb/tb_wishbone_crossbar.sv
// Bench for wishbone_crossbar: directed scenarios followed by random master traffic checked
// cycle by cycle against a window/round-robin reference model.
module tb_wishbone_crossbar;
  localparam int MC = 2;
  localparam int SC = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          sys_clk, sys_rst;
  logic [MC-1:0] m_cyc, m_stb, m_we, m_ack, m_err;
  logic [3*MC-1:0]  m_tag;
  logic [4*MC-1:0]  m_sel;
  logic [AW*MC-1:0] m_adr;
  logic [DW*MC-1:0] m_mosi, m_miso;
  logic [SC-1:0] s_cyc, s_stb, s_we, s_ack, s_err;
  logic [3*SC-1:0]  s_tag;
  logic [4*SC-1:0]  s_sel;
  logic [AW*SC-1:0] s_adr;
  logic [DW*SC-1:0] s_mosi, s_miso;

  logic        use_fixed;
  logic [31:0] s0_fixed;
  int n_checks = 0;
  int n_fail = 0;

  wishbone_crossbar #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASTER_COUNT(MC), .SLAVE_COUNT(SC),
    .SLAVE_ADDR({32'h0000_0000, 32'h0000_0400}),
    .SLAVE_MASK({32'h0000_03FF, 32'h0000_03FF})
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_tag(m_tag), .m_sel(m_sel),
    .m_adr(m_adr), .m_mosi(m_mosi), .m_miso(m_miso), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_tag(s_tag), .s_sel(s_sel),
    .s_adr(s_adr), .s_mosi(s_mosi), .s_miso(s_miso), .s_ack(s_ack), .s_err(s_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Slave 0 owns 0x400-0x7FF, slave 1 owns 0x000-0x3FF, the rest is unmapped.
  function automatic int hit_of(logic [31:0] a);
    if (a < 32'h400) return 1;
    if (a < 32'h800) return 0;
    return -1;
  endfunction

  function automatic logic slv_err(logic [31:0] a);
    return a[3:2] == 2'b11;
  endfunction

  function automatic logic [31:0] slv_data(int i, logic [31:0] a);
    return (a << 4) ^ (32'(i + 1) << 28) ^ 32'h0000_C0DE;
  endfunction

  always_comb begin
    s_ack  = '0;
    s_err  = '0;
    s_miso = '0;
    for (int i = 0; i < SC; i++) begin
      s_ack[i] = s_stb[i] & ~slv_err(s_adr[i*AW +: AW]);
      s_err[i] = s_stb[i] & slv_err(s_adr[i*AW +: AW]);
      s_miso[i*DW +: DW] = (i == 0 && use_fixed) ? s0_fixed : slv_data(i, s_adr[i*AW +: AW]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge sys_clk);
  endtask

  task automatic drive(input int j, input logic cyc, input logic we, input logic [31:0] adr,
                       input logic [2:0] tag, input logic [3:0] sel, input logic [31:0] dat);
    m_cyc[j] = cyc;
    m_stb[j] = cyc;
    m_we[j]  = we;
    m_adr[j*AW +: AW]  = adr;
    m_tag[j*3 +: 3]    = tag;
    m_sel[j*4 +: 4]    = sel;
    m_mosi[j*DW +: DW] = dat;
  endtask

  task automatic do_reset;
    m_cyc = '0;
    m_stb = '0;
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  // Reference model state: owner per slave (-1 idle), last owner, pending unmapped err.
  int own[SC];
  int last[SC];
  bit errq[MC];

  task automatic model_reset;
    for (int i = 0; i < SC; i++) begin own[i] = -1; last[i] = MC - 1; end
    for (int j = 0; j < MC; j++) errq[j] = 1'b0;
  endtask

  task automatic model_check;
    logic [SC-1:0] e_cyc, e_stb, e_we;
    logic [MC-1:0] e_ack, e_err;
    logic [AW*SC-1:0] e_adr;
    logic [DW*SC-1:0] e_mosi;
    logic [DW*MC-1:0] e_miso;
    logic [3*SC-1:0] e_tag;
    logic [4*SC-1:0] e_sel;
    logic [31:0] a;
    int o;
    e_cyc = '0; e_stb = '0; e_we = '0; e_ack = '0; e_err = '0;
    e_adr = '0; e_mosi = '0; e_miso = '0; e_tag = '0; e_sel = '0;
    for (int i = 0; i < SC; i++) begin
      o = own[i];
      if (o >= 0) begin
        a = m_adr[o*AW +: AW];
        e_cyc[i] = m_cyc[o];
        e_stb[i] = m_stb[o];
        e_we[i]  = m_we[o];
        e_adr[i*AW +: AW]  = a;
        e_mosi[i*DW +: DW] = m_mosi[o*DW +: DW];
        e_tag[i*3 +: 3] = m_tag[o*3 +: 3];
        e_sel[i*4 +: 4] = m_sel[o*4 +: 4];
        if (m_stb[o]) begin
          if (slv_err(a)) e_err[o] = 1'b1;
          else e_ack[o] = 1'b1;
        end
        e_miso[o*DW +: DW] = slv_data(i, a);
      end
    end
    for (int j = 0; j < MC; j++) if (errq[j]) e_err[j] = 1'b1;
    chk("rnd_s_cyc", 64'(s_cyc), 64'(e_cyc));
    chk("rnd_s_stb", 64'(s_stb), 64'(e_stb));
    chk("rnd_s_we", 64'(s_we), 64'(e_we));
    chk("rnd_s_adr", 64'(s_adr), 64'(e_adr));
    chk("rnd_s_mosi", 64'(s_mosi), 64'(e_mosi));
    chk("rnd_s_tag_sel", 64'({s_tag, s_sel}), 64'({e_tag, e_sel}));
    chk("rnd_m_ack", 64'(m_ack), 64'(e_ack));
    chk("rnd_m_err", 64'(m_err), 64'(e_err));
    chk("rnd_m_miso", 64'(m_miso), 64'(e_miso));
  endtask

  // Advance the model across the coming edge using the inputs that will be sampled there.
  task automatic model_step;
    bit nerr[MC];
    bit done;
    int c;
    if (sys_rst) begin
      model_reset();
      return;
    end
    for (int j = 0; j < MC; j++)
      nerr[j] = m_cyc[j] && m_stb[j] && hit_of(m_adr[j*AW +: AW]) < 0 && !errq[j];
    for (int i = 0; i < SC; i++) begin
      if (own[i] >= 0) begin
        if (!m_cyc[own[i]]) own[i] = -1;
      end else begin
        done = 1'b0;
        for (int k = 1; k <= MC; k++) begin
          c = (last[i] + k) % MC;
          if (!done && m_cyc[c] && hit_of(m_adr[c*AW +: AW]) == i) begin
            own[i] = c;
            last[i] = c;
            done = 1'b1;
          end
        end
      end
    end
    for (int j = 0; j < MC; j++) errq[j] = nerr[j];
  endtask

  int order[$];
  int gap[MC];

  initial begin
    use_fixed = 1'b0;
    s0_fixed = 32'h0;
    m_we = '0; m_tag = '0; m_sel = '0; m_adr = '0; m_mosi = '0;
    // Reset held with both masters requesting
    sys_rst = 1'b1;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    tick();
    tick();
    chk("rst_s_cyc", 64'(s_cyc), 64'h0);
    chk("rst_s_stb", 64'(s_stb), 64'h0);
    chk("rst_s_adr", 64'(s_adr), 64'h0);
    chk("rst_m_ack", 64'(m_ack), 64'h0);
    chk("rst_m_err", 64'(m_err), 64'h0);
    chk("rst_m_miso", 64'(m_miso), 64'h0);
    sys_rst = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    tick();
    chk("post_rst_s_cyc", 64'(s_cyc), 64'h0);
    chk("post_rst_m_err", 64'(m_err), 64'h0);

    // Single master to 0x000 lands on slave 1 one cycle later
    drive(0, 1'b1, 1'b1, 32'h000, 3'd5, 4'hA, 32'h1234_5678);
    #1;
    chk("pre_grant_s_cyc", 64'(s_cyc), 64'h0);
    tick();
    chk("single_s_cyc", 64'(s_cyc), 64'h2);
    chk("single_s_stb", 64'(s_stb), 64'h2);
    chk("single_s_we", 64'(s_we), 64'h2);
    chk("single_m_ack", 64'(m_ack), 64'h1);
    chk("single_tag", 64'(s_tag[5:3]), 64'h5);
    chk("single_sel", 64'(s_sel[7:4]), 64'hA);
    chk("single_mosi", 64'(s_mosi[63:32]), 64'h1234_5678);
    chk("single_miso", 64'(m_miso[31:0]), 64'(slv_data(1, 32'h0)));
    drive(0, 1'b0, 1'b0, 32'h000, 3'd0, 4'h0, 32'h0);
    tick();
    chk("release_s_cyc", 64'(s_cyc), 64'h0);

    // Two masters contending for slave 1
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h000, 3'd1, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h000, 3'd2, 4'hF, 32'h0);
    for (int t = 0; t < 20 && order.size() < 4; t++) begin
      tick();
      chk("ack_exclusive", 64'(m_ack[0] & m_ack[1]), 64'h0);
      for (int j = 0; j < MC; j++) begin
        if (m_ack[j]) begin
          order.push_back(j);
          m_cyc[j] = 1'b0;
          m_stb[j] = 1'b0;
        end else if (!m_cyc[j]) begin
          m_cyc[j] = 1'b1;
          m_stb[j] = 1'b1;
        end
      end
    end
    chk("rr_ack_count", 64'(order.size()), 64'd4);
    for (int k = 0; k < order.size(); k++) chk("rr_order", 64'(order[k]), 64'(k % 2));
    m_cyc = '0;
    m_stb = '0;

    // Different slaves proceed concurrently
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h000, 3'd0, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h400, 3'd0, 4'hF, 32'h0);
    tick();
    chk("conc_s_cyc", 64'(s_cyc), 64'h3);
    chk("conc_m_ack", 64'(m_ack), 64'h3);
    m_cyc = '0;
    m_stb = '0;
    tick();

    // Read data routed only to the owner
    use_fixed = 1'b1;
    s0_fixed = 32'hDEAD_BEEF;
    drive(1, 1'b1, 1'b0, 32'h404, 3'd0, 4'hF, 32'h0);
    tick();
    chk("read_m_miso", 64'(m_miso), {32'hDEAD_BEEF, 32'h0});
    chk("read_m_ack", 64'(m_ack), 64'h2);
    m_cyc = '0;
    m_stb = '0;
    use_fixed = 1'b0;
    tick();

    // Unmapped access: err pulse every other cycle, no slave activity
    drive(0, 1'b1, 1'b0, 32'h800, 3'd0, 4'hF, 32'h0);
    tick();
    chk("unmap_err1", 64'(m_err), 64'h1);
    chk("unmap_ack", 64'(m_ack), 64'h0);
    chk("unmap_s_cyc", 64'(s_cyc), 64'h0);
    tick();
    chk("unmap_err_gap", 64'(m_err), 64'h0);
    tick();
    chk("unmap_err2", 64'(m_err), 64'h1);
    m_cyc = '0;
    m_stb = '0;
    tick();
    chk("unmap_err_end", 64'(m_err), 64'h0);

    // Reset during an owned transfer
    drive(0, 1'b1, 1'b0, 32'h000, 3'd0, 4'hF, 32'h0);
    tick();
    chk("midrst_owned", 64'(s_cyc), 64'h2);
    sys_rst = 1'b1;
    tick();
    chk("midrst_s_cyc", 64'(s_cyc), 64'h0);
    chk("midrst_m_ack", 64'(m_ack), 64'h0);
    sys_rst = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    tick();
    chk("midrst_after", 64'(m_ack), 64'h0);

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int j = 0; j < MC; j++) gap[j] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_check();
      sys_rst = ($urandom_range(0, 299) == 0);
      for (int j = 0; j < MC; j++) begin
        if (m_cyc[j]) begin
          if (m_ack[j] || m_err[j]) begin
            m_cyc[j] = 1'b0;
            m_stb[j] = 1'b0;
            gap[j] = $urandom_range(1, 3);
          end
        end else if (gap[j] > 0) begin
          gap[j]--;
        end else begin
          int r;
          logic [31:0] a;
          r = $urandom_range(0, 9);
          a = 32'($urandom_range(0, 255)) << 2;
          if (r >= 9) a = a | 32'h800;
          else if (r >= 5) a = a | 32'h400;
          drive(j, 1'b1, 1'($urandom), a, 3'($urandom), 4'($urandom), $urandom);
        end
      end
      model_step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
